// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package reg_file_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clr_state_e;

   // Widest entry the merge helper handles; callers zero-extend and truncate.
   localparam int unsigned MERGE_MAX_W  = 256;
   localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

   // Take new_v bytes where be is set, old_v bytes elsewhere.
   function automatic logic [MERGE_MAX_W-1:0] byte_merge(
      input logic [MERGE_MAX_W-1:0]  old_v,
      input logic [MERGE_MAX_W-1:0]  new_v,
      input logic [MERGE_MAX_BE-1:0] be
   );
      logic [MERGE_MAX_W-1:0] m;
      m = old_v;
      for (int i = 0; i < int'(MERGE_MAX_BE); i++) begin
         if (be[i]) m[8*i +: 8] = new_v[8*i +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// Sequential clear engine: walks every entry once after reset or on request.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   CLEAR | zeroing entry[cnt_q] each cycle, busy high, user ops dropped
//   IDLE  | normal operation, clr_req_i restarts the sweep at entry 0
module reg_file_clr_ctrl
   import reg_file_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_req_i,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // next state: advance the sweep, leave CLEAR after the last entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         IDLE: begin
            if (clr_req_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // state and counter registers, reset restarts the sweep
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o     = (state_q == CLEAR);
   assign clr_we_o   = busy_o && !rst_i;
   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file, one byte-enabled write port and two registered read ports
// with write-first bypass; contents zeroed by a sequential clear engine.
module reg_file_2r1w
   import reg_file_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [BE_W-1:0]   wr_be_i,
   input  logic              rd0_en_i,
   input  logic [ADDR_W-1:0] rd0_addr_i,
   output logic [DATA_W-1:0] rd0_data_o,
   output logic              rd0_valid_o,
   input  logic              rd1_en_i,
   input  logic [ADDR_W-1:0] rd1_addr_i,
   output logic [DATA_W-1:0] rd1_data_o,
   output logic              rd1_valid_o,
   input  logic              clr_req_i,
   output logic              busy_o
);

   localparam int unsigned   AW1     = ADDR_W + 1;
   localparam logic [AW1-1:0] DEPTH_C = AW1'(DEPTH);

   // Only non-power-of-2 depths can see an address past the last entry.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_C;
   endfunction

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   reg_file_clr_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_ctrl (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_req_i  (clr_req_i),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   assign busy_o = busy;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              user_we;
   logic [DATA_W-1:0] wr_merged;

   assign user_we   = wr_en_i && !busy && !rst_i && in_range(wr_addr_i);
   assign wr_merged = DATA_W'(byte_merge(MERGE_MAX_W'(mem_q[wr_addr_i]),
                                         MERGE_MAX_W'(wr_data_i),
                                         MERGE_MAX_BE'(wr_be_i)));

   // array update; clear and user writes are mutually exclusive via busy
   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (user_we) begin
         mem_q[wr_addr_i] <= wr_merged;
      end
   end

   logic              rd_en    [2];
   logic [ADDR_W-1:0] rd_addr  [2];
   logic [DATA_W-1:0] rd_data  [2];
   logic              rd_valid [2];

   assign rd_en[0]   = rd0_en_i;
   assign rd_en[1]   = rd1_en_i;
   assign rd_addr[0] = rd0_addr_i;
   assign rd_addr[1] = rd1_addr_i;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic              hit;
      logic [BE_W-1:0]   byp_be;
      logic [DATA_W-1:0] data_q, data_d;
      logic              valid_q, valid_d;

      assign hit    = user_we && (wr_addr_i == rd_addr[p]);
      assign byp_be = hit ? wr_be_i : '0;

      // read next-state: write-first merge, zero for out-of-range, hold when idle
      always_comb begin
         valid_d = 1'b0;
         data_d  = data_q;
         if (!busy && rd_en[p]) begin
            valid_d = 1'b1;
            if (!in_range(rd_addr[p])) begin
               data_d = '0;
            end else begin
               data_d = DATA_W'(byte_merge(MERGE_MAX_W'(mem_q[rd_addr[p]]),
                                           MERGE_MAX_W'(wr_data_i),
                                           MERGE_MAX_BE'(byp_be)));
            end
         end
      end

      // registered read outputs
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end

      assign rd_data[p]  = data_q;
      assign rd_valid[p] = valid_q;
   end

   assign rd0_data_o  = rd_data[0];
   assign rd0_valid_o = rd_valid[0];
   assign rd1_data_o  = rd_data[1];
   assign rd1_valid_o = rd_valid[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench: DEPTH=8 instance for the main scenarios, DEPTH=6 for range checks.
module tb_reg_file_2r1w;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd0_en, rd1_en, clr_req;
   logic [2:0]  wr_addr, rd0_addr, rd1_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [31:0] rd0_data, rd1_data;
   logic        rd0_valid, rd1_valid, busy;

   logic        w6_wr_en, w6_rd0_en, w6_rd1_en, w6_clr_req;
   logic [2:0]  w6_wr_addr, w6_rd0_addr, w6_rd1_addr;
   logic [31:0] w6_wr_data;
   logic [3:0]  w6_wr_be;
   logic [31:0] w6_rd0_data, w6_rd1_data;
   logic        w6_rd0_valid, w6_rd1_valid, w6_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_file_2r1w #(.DATA_W(32), .DEPTH(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
      .rd0_en_i(rd0_en), .rd0_addr_i(rd0_addr), .rd0_data_o(rd0_data), .rd0_valid_o(rd0_valid),
      .rd1_en_i(rd1_en), .rd1_addr_i(rd1_addr), .rd1_data_o(rd1_data), .rd1_valid_o(rd1_valid),
      .clr_req_i(clr_req), .busy_o(busy)
   );

   reg_file_2r1w #(.DATA_W(32), .DEPTH(6)) u_dut6 (
      .clk_i(clk), .rst_i(rst),
      .wr_en_i(w6_wr_en), .wr_addr_i(w6_wr_addr), .wr_data_i(w6_wr_data), .wr_be_i(w6_wr_be),
      .rd0_en_i(w6_rd0_en), .rd0_addr_i(w6_rd0_addr), .rd0_data_o(w6_rd0_data), .rd0_valid_o(w6_rd0_valid),
      .rd1_en_i(w6_rd1_en), .rd1_addr_i(w6_rd1_addr), .rd1_data_o(w6_rd1_data), .rd1_valid_o(w6_rd1_valid),
      .clr_req_i(w6_clr_req), .busy_o(w6_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr8(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd8(input logic [2:0] a0, input logic [2:0] a1);
      rd0_en = 1'b1; rd0_addr = a0; rd1_en = 1'b1; rd1_addr = a1;
      step();
      rd0_en = 1'b0; rd1_en = 1'b0;
   endtask

   task automatic wr6(input logic [2:0] a, input logic [31:0] d);
      w6_wr_en = 1'b1; w6_wr_addr = a; w6_wr_data = d; w6_wr_be = 4'hF;
      step();
      w6_wr_en = 1'b0;
   endtask

   task automatic rd6(input logic [2:0] a0, input logic [2:0] a1);
      w6_rd0_en = 1'b1; w6_rd0_addr = a0; w6_rd1_en = 1'b1; w6_rd1_addr = a1;
      step();
      w6_rd0_en = 1'b0; w6_rd1_en = 1'b0;
   endtask

   // cycles until busy drops, bounded
   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      logic [31:0] exp6 [6];

      rst = 1'b1;
      wr_en = 0; rd0_en = 0; rd1_en = 0; clr_req = 0;
      wr_addr = 0; rd0_addr = 0; rd1_addr = 0; wr_data = 0; wr_be = 0;
      w6_wr_en = 0; w6_rd0_en = 0; w6_rd1_en = 0; w6_clr_req = 0;
      w6_wr_addr = 0; w6_rd0_addr = 0; w6_rd1_addr = 0; w6_wr_data = 0; w6_wr_be = 0;
      step();
      step();

      // reset state
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_v0", 32'(rd0_valid), 32'd0);
      chk("rst_v1", 32'(rd1_valid), 32'd0);
      chk("rst_d0", rd0_data, 32'h0);
      chk("rst_d1", rd1_data, 32'h0);

      // 1: busy for DEPTH cycles after release, both instances
      rst = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
         if (n == 5) chk("d6_busy_5", 32'(w6_busy), 32'd1);
         if (n == 6) chk("d6_busy_6", 32'(w6_busy), 32'd0);
      end
      chk("init_busy_len", 32'(n), 32'd8);
      for (int i = 0; i < 8; i++) begin
         rd8(3'(i), 3'(7 - i));
         chk("init_rd0", rd0_data, 32'h0);
         chk("init_v0", 32'(rd0_valid), 32'd1);
         chk("init_rd1", rd1_data, 32'h0);
         chk("init_v1", 32'(rd1_valid), 32'd1);
      end
      step();
      chk("rd_idle_v0", 32'(rd0_valid), 32'd0);

      // 2: partial byte write
      wr8(3'd3, 32'hDEADBEEF, 4'hF);
      wr8(3'd3, 32'h11223344, 4'b0101);
      rd8(3'd3, 3'd3);
      chk("be_merge0", rd0_data, 32'hDE22BE44);
      chk("be_merge1", rd1_data, 32'hDE22BE44);
      wr8(3'd3, 32'hFFFFFFFF, 4'b0000);
      rd8(3'd3, 3'd0);
      chk("be_none", rd0_data, 32'hDE22BE44);

      // 3: write-first bypass on both ports
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
      rd0_en = 1'b1; rd0_addr = 3'd5; rd1_en = 1'b1; rd1_addr = 3'd5;
      step();
      chk("byp_full0", rd0_data, 32'hCAFEF00D);
      chk("byp_full1", rd1_data, 32'hCAFEF00D);
      wr_addr = 3'd6; rd0_addr = 3'd6; rd1_addr = 3'd6; wr_be = 4'b1000;
      step();
      wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
      chk("byp_part0", rd0_data, 32'hCA000000);
      chk("byp_part1", rd1_data, 32'hCA000000);
      step();
      chk("hold_d0", rd0_data, 32'hCA000000);
      chk("hold_v0", 32'(rd0_valid), 32'd0);
      rd8(3'd6, 3'd5);
      chk("byp_stored6", rd0_data, 32'hCA000000);
      chk("byp_stored5", rd1_data, 32'hCAFEF00D);

      // 4: clear request concurrent with write and read
      for (int i = 0; i < 8; i++) wr8(3'(i), 32'hA0 + 32'(i), 4'hF);
      rd8(3'd2, 3'd7);
      chk("fill2", rd0_data, 32'hA2);
      chk("fill7", rd1_data, 32'hA7);
      clr_req = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h55; wr_be = 4'hF;
      rd0_en = 1'b1; rd0_addr = 3'd1; rd1_en = 1'b1; rd1_addr = 3'd4;
      step();
      clr_req = 1'b0;
      chk("clr_rd0", rd0_data, 32'h55);
      chk("clr_rd1", rd1_data, 32'hA4);
      chk("clr_v0", 32'(rd0_valid), 32'd1);
      chk("clr_busy", 32'(busy), 32'd1);
      wr_addr = 3'd2; wr_data = 32'hFFFFFFFF;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
         chk("busy_v0", 32'(rd0_valid), 32'd0);
         chk("busy_v1", 32'(rd1_valid), 32'd0);
         chk("busy_hold0", rd0_data, 32'h55);
      end
      wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
      chk("clr_busy_len", 32'(n), 32'd8);
      for (int i = 0; i < 8; i++) begin
         rd8(3'(i), 3'(i));
         chk("post_clr0", rd0_data, 32'h0);
         chk("post_clr1", rd1_data, 32'h0);
      end

      // 5: reset in the middle of a clear
      wr8(3'd7, 32'h77, 4'hF);
      rd8(3'd7, 3'd7);
      chk("pre5_rd", rd0_data, 32'h77);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_d0", rd0_data, 32'h0);
      chk("mid_rst_v0", 32'(rd0_valid), 32'd0);
      rst = 1'b0;
      busy_len(n);
      chk("mid_busy_len", 32'(n), 32'd8);
      rd8(3'd7, 3'd4);
      chk("mid_rd7", rd0_data, 32'h0);
      chk("mid_rd4", rd1_data, 32'h0);

      // 6: DEPTH=6 out-of-range handling
      for (int i = 0; i < 6; i++) exp6[i] = 32'h0;
      exp6[2] = 32'h22222222;
      exp6[4] = 32'h44444444;
      wr6(3'd2, 32'h22222222);
      wr6(3'd4, 32'h44444444);
      wr6(3'd7, 32'h77777777);
      rd6(3'd7, 3'd6);
      chk("d6_oor_d0", w6_rd0_data, 32'h0);
      chk("d6_oor_v0", 32'(w6_rd0_valid), 32'd1);
      chk("d6_oor_d1", w6_rd1_data, 32'h0);
      w6_wr_en = 1'b1; w6_wr_addr = 3'd7; w6_wr_data = 32'h12345678; w6_wr_be = 4'hF;
      w6_rd0_en = 1'b1; w6_rd0_addr = 3'd7; w6_rd1_en = 1'b1; w6_rd1_addr = 3'd2;
      step();
      w6_wr_en = 1'b0; w6_rd0_en = 1'b0; w6_rd1_en = 1'b0;
      chk("d6_oor_byp", w6_rd0_data, 32'h0);
      chk("d6_oor_byp2", w6_rd1_data, 32'h22222222);
      rd6(3'd2, 3'd4);
      chk("d6_rd2", w6_rd0_data, 32'h22222222);
      chk("d6_rd4", w6_rd1_data, 32'h44444444);
      for (int i = 0; i < 6; i++) begin
         rd6(3'(i), 3'(5 - i));
         chk("d6_all0", w6_rd0_data, exp6[i]);
         chk("d6_all1", w6_rd1_data, exp6[5 - i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file with one write port and two read ports.
- Writes are byte-enabled; reads are registered with write-first bypass.
- A built-in sequential clear engine zeroes every entry after reset or on request.
- Sits beside datapath units that need two operands per cycle and a deterministic known-zero state after init.

Parameters:
- DATA_W, 32, entry width in bits; multiple of 8, minimum 8.
- DEPTH, 8, number of entries; minimum 2, power of 2 not required.
- ADDR_W, $clog2(DEPTH), address width (derived localparam, not overridable).
- BE_W, DATA_W/8, byte-enable width (derived localparam).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
- rd0_en  in  1  read request, port 0.
- rd0_addr  in  ADDR_W  read address, port 0.
- rd0_data  out  DATA_W  read data, port 0.
- rd0_valid  out  1  rd0_data valid this cycle.
- rd1_en, rd1_addr, rd1_data, rd1_valid  as port 0, for port 1.
- clr_req  in  1  request full-array clear.
- busy  out  1  clear in progress; all requests dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - state=CLEAR, clear counter=0.
  - busy=1, rd0/rd1_data=0, rd0/rd1_valid=0.
  - Array contents are not reset directly; the clear engine zeroes them.
- CLEAR state:
  - Each edge with rst=0 writes 0 to entry[cnt], then cnt++.
  - On the edge that clears entry DEPTH-1, state goes to IDLE and busy goes to 0.
  - busy is therefore high for exactly DEPTH cycles after rst is released.
  - rst during CLEAR restarts at cnt=0.
  - clr_req is ignored in CLEAR.
- IDLE state:
  - clr_req=1 at an edge moves to CLEAR with cnt=0; busy=1 from the next cycle, for DEPTH cycles.
  - A write and reads presented in the same cycle as clr_req are still performed. The written data is subsequently cleared.
- While busy=1:
  - wr_en, rd0_en and rd1_en are dropped.
  - rdN_valid=0 and rdN_data holds its last value.
- Write:
  - At an edge with wr_en=1, busy=0 and wr_addr<DEPTH, update only the bytes whose wr_be bit is 1.
  - wr_be=0 leaves the entry unchanged.
- Read latency is 1 cycle:
  - rdN_en=1 at edge t with busy=0 gives rdN_valid=1 and rdN_data=entry at cycle t+1.
  - rdN_en=0 gives rdN_valid=0 next cycle and rdN_data holds.
- Bypass (write-first):
  - Condition: same-edge write and read to the same address.
  - Returned data takes wr_data bytes where wr_be=1 and stored bytes elsewhere.
  - Applies independently to both read ports.
- Both read ports may address the same or different entries in the same cycle with no conflict.
- Out-of-range address (addr>=DEPTH, non-power-of-2 DEPTH only):
  - The write is dropped.
  - A read returns rdN_data=0 with rdN_valid=1.
- No combinational path from inputs to outputs.

Decomposition:
- Package reg_file_pkg holds:
  - the state typedef enum {CLEAR, IDLE};
  - the byte-merge function (old, new, be) -> merged, used by both the write and bypass paths.
- Sub-module reg_file_clr_ctrl holds the state register, clear counter, busy output, and the clear write-enable/address.
- The top level muxes the clear write over the user write.

Test Plan:
1. Release rst with DEPTH=8 -> busy=1 for 8 cycles, then 0. Read every address -> data 0x00000000, valid=1 one cycle after each request.
2. Write addr 3, 0xDEADBEEF, be=4'hF; next cycle write addr 3, 0x11223344, be=4'b0101; then read -> 0xDE22BE44.
3. Same edge: write addr 5, 0xCAFEF00D, be=4'hF, with rd0_addr=5 and rd1_addr=5 -> both ports return 0xCAFEF00D next cycle. Repeat with be=4'b1000 over stored 0x00000000 -> both return 0xCA000000.
4. Fill entries 0..7 with 0xA0+i; assert clr_req together with a write 0x55 to addr 1 -> busy for 8 cycles; reads and writes issued during busy give valid=0 and no array change; afterwards all entries read 0.
5. Assert rst at cnt=4 mid-clear -> busy stays 1 for 8 further cycles after release; all entries read 0.
6. DEPTH=6: write addr 7 -> no entry changes; read addr 7 -> data 0, valid=1. Concurrent rd0_addr=2 / rd1_addr=4 return independent correct values.
